// File: rtl/switch_port.sv
// -----------------------------------------------------------------------------
// switch_port
//   Switch-side endpoint for one device port of the 4-port switch.
//
//   Ingress: the device offers {adr, dat} under a valid/ack handshake. Accepted
//   words go into a DEPTH-entry FIFO whose head is presented to the fabric.
//   Egress: the fabric pushes words into a DEPTH-entry FIFO that streams them
//   to the device under a valid/ack handshake.
//
// Ports
//   clk_i, rst_ni              clock (rising edge), async active-low reset
//   dev_valid_i/adr_i/dat_i    device transmit offer (held until acked)
//   dev_ack_o                  registered one-cycle accept pulse to device
//   fab_valid_o/adr_o/dat_o    ingress FIFO head offered to the fabric
//   fab_pop_i                  fabric consumes ingress head
//   eg_push_i/eg_dat_i         fabric writes a word for this device
//   eg_full_o                  egress FIFO full
//   dev_valid_o/dat_o          receive offer to device
//   dev_ack_i                  device receive ack (may be held to stream)
//   ovf_o                      sticky: egress push attempted while full
// -----------------------------------------------------------------------------
module switch_port #(
  parameter int DW    = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          dev_valid_i,
  input  logic [1:0]    dev_adr_i,
  input  logic [DW-1:0] dev_dat_i,
  output logic          dev_ack_o,
  output logic          fab_valid_o,
  output logic [1:0]    fab_adr_o,
  output logic [DW-1:0] fab_dat_o,
  input  logic          fab_pop_i,
  input  logic          eg_push_i,
  input  logic [DW-1:0] eg_dat_i,
  output logic          eg_full_o,
  output logic          dev_valid_o,
  output logic [DW-1:0] dev_dat_o,
  input  logic          dev_ack_i,
  output logic          ovf_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Pointers are AW bits wide, so the natural overflow wraps modulo DEPTH.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return p + AW'(1);
  endfunction

  function automatic logic [AW:0] cnt_next(input logic [AW:0] c,
                                           input logic        inc,
                                           input logic        dec);
    logic [AW:0] r;
    r = c;
    if (inc && !dec)      r = c + (AW+1)'(1);
    else if (!inc && dec) r = c - (AW+1)'(1);
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Ingress side
  // ---------------------------------------------------------------------------
  logic [DW+1:0] in_mem_q [DEPTH];
  logic [AW-1:0] in_wr_q, in_wr_d;
  logic [AW-1:0] in_rd_q, in_rd_d;
  logic [AW:0]   in_cnt_q, in_cnt_d;
  logic          ack_q, ack_d;
  logic          in_cap, in_pop;

  always_comb begin
    in_cap   = dev_valid_i & ack_q;
    in_pop   = fab_pop_i & (in_cnt_q != '0);
    in_wr_d  = in_cap ? ptr_inc(in_wr_q) : in_wr_q;
    in_rd_d  = in_pop ? ptr_inc(in_rd_q) : in_rd_q;
    in_cnt_d = cnt_next(in_cnt_q, in_cap, in_pop);
    // Fullness is judged on the post-edge count so a capture landing on the
    // same edge is already accounted for; ~ack_q forces a gap between acks.
    ack_d    = dev_valid_i & ~ack_q & (in_cnt_d != FULL_CNT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_wr_q  <= '0;
      in_rd_q  <= '0;
      in_cnt_q <= '0;
      ack_q    <= 1'b0;
    end else begin
      in_wr_q  <= in_wr_d;
      in_rd_q  <= in_rd_d;
      in_cnt_q <= in_cnt_d;
      ack_q    <= ack_d;
    end
  end

  // Storage carries no reset; only the pointers/counts define what is valid.
  always_ff @(posedge clk_i) begin
    if (in_cap) in_mem_q[in_wr_q] <= {dev_adr_i, dev_dat_i};
  end

  assign dev_ack_o              = ack_q;
  assign fab_valid_o            = (in_cnt_q != '0);
  assign {fab_adr_o, fab_dat_o} = in_mem_q[in_rd_q];

  // ---------------------------------------------------------------------------
  // Egress side
  // ---------------------------------------------------------------------------
  logic [DW-1:0] eg_mem_q [DEPTH];
  logic [AW-1:0] eg_wr_q, eg_wr_d;
  logic [AW-1:0] eg_rd_q, eg_rd_d;
  logic [AW:0]   eg_cnt_q, eg_cnt_d;
  logic          ovf_q, ovf_d;
  logic          eg_full, eg_wr, eg_pop;

  always_comb begin
    // Push is judged against the pre-edge count: a push while full is
    // dropped even if the device pops on the same edge.
    eg_full  = (eg_cnt_q == FULL_CNT);
    eg_wr    = eg_push_i & ~eg_full;
    eg_pop   = dev_ack_i & (eg_cnt_q != '0);
    eg_wr_d  = eg_wr  ? ptr_inc(eg_wr_q) : eg_wr_q;
    eg_rd_d  = eg_pop ? ptr_inc(eg_rd_q) : eg_rd_q;
    eg_cnt_d = cnt_next(eg_cnt_q, eg_wr, eg_pop);
    ovf_d    = ovf_q | (eg_push_i & eg_full);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      eg_wr_q  <= '0;
      eg_rd_q  <= '0;
      eg_cnt_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      eg_wr_q  <= eg_wr_d;
      eg_rd_q  <= eg_rd_d;
      eg_cnt_q <= eg_cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (eg_wr) eg_mem_q[eg_wr_q] <= eg_dat_i;
  end

  assign eg_full_o   = eg_full;
  assign dev_valid_o = (eg_cnt_q != '0);
  assign dev_dat_o   = eg_mem_q[eg_rd_q];
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_switch_port.sv
// -----------------------------------------------------------------------------
// tb_switch_port
//   Randomized scoreboard bench for switch_port. A driver process plays the
//   device and the fabric; a monitor process keeps a queue-based reference
//   model of both FIFOs and the ack rule and checks the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_switch_port;

  localparam int DW    = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dev_valid_i;
  logic [1:0]    dev_adr_i;
  logic [DW-1:0] dev_dat_i;
  logic          dev_ack_o;
  logic          fab_valid_o;
  logic [1:0]    fab_adr_o;
  logic [DW-1:0] fab_dat_o;
  logic          fab_pop_i;
  logic          eg_push_i;
  logic [DW-1:0] eg_dat_i;
  logic          eg_full_o;
  logic          dev_valid_o;
  logic [DW-1:0] dev_dat_o;
  logic          dev_ack_i;
  logic          ovf_o;

  switch_port #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .dev_valid_i (dev_valid_i),
    .dev_adr_i   (dev_adr_i),
    .dev_dat_i   (dev_dat_i),
    .dev_ack_o   (dev_ack_o),
    .fab_valid_o (fab_valid_o),
    .fab_adr_o   (fab_adr_o),
    .fab_dat_o   (fab_dat_o),
    .fab_pop_i   (fab_pop_i),
    .eg_push_i   (eg_push_i),
    .eg_dat_i    (eg_dat_i),
    .eg_full_o   (eg_full_o),
    .dev_valid_o (dev_valid_o),
    .dev_dat_o   (dev_dat_o),
    .dev_ack_i   (dev_ack_i),
    .ovf_o       (ovf_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model + monitor (evaluated mid-cycle, at the falling edge)
  // ---------------------------------------------------------------------------
  logic [DW+1:0] in_q [$];   // words expected in the ingress FIFO, head first
  logic [DW-1:0] eg_q [$];   // words expected in the egress FIFO, head first
  logic          ack_e = 1'b0;
  logic          ovf_e = 1'b0;

  always @(negedge clk) begin
    logic cap, full_pre;
    if (!rst_n) begin
      in_q.delete();
      eg_q.delete();
      ack_e = 1'b0;
      ovf_e = 1'b0;
    end else begin
      chk("dev_ack",   dev_ack_o,   ack_e);
      chk("fab_valid", fab_valid_o, in_q.size() != 0);
      if (in_q.size() != 0 && fab_pop_i)
        chk("fab_head", {fab_adr_o, fab_dat_o}, in_q[0]);
      chk("eg_full",   eg_full_o,   eg_q.size() == DEPTH);
      chk("dev_valid", dev_valid_o, eg_q.size() != 0);
      if (eg_q.size() != 0 && dev_ack_i)
        chk("dev_dat", dev_dat_o, eg_q[0]);
      chk("ovf", ovf_o, ovf_e);

      // Apply what happens at the coming rising edge.
      cap = dev_valid_i && ack_e;
      if (fab_pop_i && in_q.size() != 0) void'(in_q.pop_front());
      if (cap) in_q.push_back({dev_adr_i, dev_dat_i});
      ack_e = dev_valid_i && !ack_e && (in_q.size() != DEPTH);

      full_pre = (eg_q.size() == DEPTH);
      if (dev_ack_i && eg_q.size() != 0) void'(eg_q.pop_front());
      if (eg_push_i) begin
        if (full_pre) ovf_e = 1'b1;
        else          eg_q.push_back(eg_dat_i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: device transmitter/receiver and fabric
  // ---------------------------------------------------------------------------
  logic [DW+1:0] src_q [$];    // device words still to be offered
  logic [DW-1:0] eg_src [$];   // directed egress words
  int unsigned   p_pop  = 0;
  int unsigned   p_push = 0;
  int unsigned   p_ack  = 0;
  int unsigned   p_drop = 0;

  task automatic step();
    logic cap;
    @(negedge clk);
    cap = dev_valid_i & dev_ack_o;
    @(posedge clk);
    #1;
    if (cap) void'(src_q.pop_front());
    dev_valid_i = 1'b0;
    if (src_q.size() != 0) begin
      {dev_adr_i, dev_dat_i} = src_q[0];
      dev_valid_i = !(dev_ack_o && ($urandom_range(99) < p_drop));
    end
    fab_pop_i = ($urandom_range(99) < p_pop);
    dev_ack_i = ($urandom_range(99) < p_ack);
    eg_push_i = 1'b0;
    if (eg_src.size() != 0) begin
      eg_push_i = 1'b1;
      eg_dat_i  = eg_src.pop_front();
    end else if ($urandom_range(99) < p_push) begin
      eg_push_i = 1'b1;
      eg_dat_i  = DW'($urandom);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_all_idle(input string nm);
    chk({nm, "_ack"},   dev_ack_o,   1'b0);
    chk({nm, "_fabv"},  fab_valid_o, 1'b0);
    chk({nm, "_full"},  eg_full_o,   1'b0);
    chk({nm, "_devv"},  dev_valid_o, 1'b0);
    chk({nm, "_ovf"},   ovf_o,       1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    dev_valid_i = 1'b0;
    dev_adr_i   = '0;
    dev_dat_i   = '0;
    fab_pop_i   = 1'b0;
    eg_push_i   = 1'b0;
    eg_dat_i    = '0;
    dev_ack_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_idle("reset");
    rst_n = 1'b1;

    // Single word: ack one cycle after valid, then visible to the fabric.
    src_q.push_back({2'd2, 4'hA});
    steps(5);
    p_pop = 100;
    steps(2);
    p_pop = 0;

    // Held valid with 5 words and no pops: only 4 accepted.
    for (int i = 0; i < 5; i++) src_q.push_back({2'(i), 4'(i + 3)});
    steps(12);
    chk("acks_while_full", 8'(src_q.size()), 8'd1);
    p_pop = 100;
    step();
    p_pop = 0;
    steps(4);
    chk("fifth_acked", 8'(src_q.size()), 8'd0);
    p_pop = 100;
    steps(6);
    p_pop = 0;

    // Egress stream with ack held high.
    p_ack = 100;
    eg_src.push_back(4'h1);
    eg_src.push_back(4'h2);
    eg_src.push_back(4'h3);
    steps(6);

    // Overflow: 5 pushes with no ack.
    p_ack = 0;
    for (int i = 0; i < 5; i++) eg_src.push_back(4'(8 + i));
    steps(7);
    chk("ovf_full", eg_full_o, 1'b1);
    chk("ovf_set",  ovf_o,     1'b1);
    p_ack = 100;
    steps(6);
    chk("ovf_sticky", ovf_o, 1'b1);
    p_ack = 0;

    // 10 words with random pops: simultaneous capture/pop and pointer wrap.
    for (int i = 0; i < 10; i++) src_q.push_back(6'($urandom));
    p_pop = 50;
    steps(40);

    // Randomized mixed traffic.
    p_pop = 60; p_push = 40; p_ack = 60; p_drop = 10;
    for (int i = 0; i < 400; i++) begin
      if (src_q.size() < 3 && $urandom_range(3) == 0) src_q.push_back(6'($urandom));
      step();
    end

    // Async reset mid-stream with both FIFOs loaded.
    p_pop = 0; p_push = 0; p_ack = 0; p_drop = 0;
    for (int i = 0; i < 3; i++) begin
      src_q.push_back(6'($urandom));
      eg_src.push_back(DW'($urandom));
    end
    steps(8);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_idle("async_rst");
    src_q.delete();
    eg_src.delete();
    dev_valid_i = 1'b0;
    fab_pop_i   = 1'b0;
    eg_push_i   = 1'b0;
    dev_ack_i   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    p_pop = 100; p_ack = 100;
    steps(5);

    // Post-reset traffic still works.
    p_pop = 50; p_push = 30; p_ack = 50;
    for (int i = 0; i < 100; i++) begin
      if (src_q.size() < 2) src_q.push_back(6'($urandom));
      step();
    end

    // Drain.
    p_push = 0; p_pop = 100; p_ack = 100;
    src_q.delete();
    steps(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
